// File: rtl/cpu_clock_ctrl.sv
// Run/step/halt clock controller: debounced operator buttons drive a small FSM that
// produces a flop-driven CPU clock at a switch-selected speed, plus a rising-edge counter.
module cpu_clock_ctrl #(
    parameter int DEB_W      = 20,
    parameter int DEB_CYCLES = 500000,
    parameter int HALF_W     = 25,
    parameter int HALF_SLOW  = 25000000,
    parameter int HALF_MID   = 250000,
    parameter int HALF_FAST  = 25000,
    parameter int HALF_FULL  = 1
) (
    input  logic        clock,
    input  logic        reset_N,
    input  logic        btn_run_N,
    input  logic        btn_step_N,
    input  logic [1:0]  sw_speed,
    output logic        cpu_clock,
    output logic        running,
    output logic [15:0] cyc_count
);

    localparam logic [1:0] ST_HALT    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_STEP_LO = 2'd2;
    localparam logic [1:0] ST_STEP_HI = 2'd3;

    localparam logic [HALF_W-1:0] LOAD_SLOW = HALF_W'(HALF_SLOW - 1);
    localparam logic [HALF_W-1:0] LOAD_MID  = HALF_W'(HALF_MID - 1);
    localparam logic [HALF_W-1:0] LOAD_FAST = HALF_W'(HALF_FAST - 1);
    localparam logic [HALF_W-1:0] LOAD_FULL = HALF_W'(HALF_FULL - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {btn_step_N, btn_run_N};

    // Index 0 is the run button, index 1 the step button.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             deb_level_reg;
            logic             deb_prev_reg;
            logic [DEB_W-1:0] deb_cnt_reg;

            always_ff @(posedge clock or negedge reset_N) begin
                if (!reset_N) begin
                    sync1_reg     <= 1'b1;
                    sync2_reg     <= 1'b1;
                    deb_level_reg <= 1'b1;
                    deb_prev_reg  <= 1'b1;
                    deb_cnt_reg   <= '0;
                end else begin
                    sync1_reg    <= btn_raw[gi];
                    sync2_reg    <= sync1_reg;
                    deb_prev_reg <= deb_level_reg;
                    // Any return to the accepted level restarts the stability count.
                    if (sync2_reg == deb_level_reg) begin
                        deb_cnt_reg <= '0;
                    end else if (deb_cnt_reg == DEB_LAST) begin
                        deb_level_reg <= sync2_reg;
                        deb_cnt_reg   <= '0;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
                    end
                end
            end

            assign press[gi] = deb_prev_reg & ~deb_level_reg;
        end
    endgenerate

    logic              run_press;
    logic              step_press;
    logic [1:0]        state_reg, state_next;
    logic [HALF_W-1:0] half_reg, half_next;
    logic [HALF_W-1:0] half_load;
    logic              clk_reg, clk_next;
    logic              stop_reg, stop_next;
    logic              running_reg;
    logic [15:0]       cnt_reg;
    logic [15:0]       cnt_next;
    logic              tick;
    logic              stop_eff;

    assign run_press  = press[0];
    assign step_press = press[1];
    assign tick       = (half_reg == '0);
    // A run press coinciding with a pending stop cancels it.
    assign stop_eff   = stop_reg ^ run_press;

    always_comb begin
        half_load = LOAD_FULL;
        case (sw_speed)
            2'd0:    half_load = LOAD_SLOW;
            2'd1:    half_load = LOAD_MID;
            2'd2:    half_load = LOAD_FAST;
            default: half_load = LOAD_FULL;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        half_next  = half_reg;
        clk_next   = clk_reg;
        stop_next  = stop_reg;
        case (state_reg)
            ST_HALT: begin
                if (run_press) begin
                    state_next = ST_RUN;
                    half_next  = half_load;
                end else if (step_press) begin
                    state_next = ST_STEP_LO;
                    half_next  = LOAD_FAST;
                end
            end
            ST_RUN: begin
                stop_next = stop_eff;
                if (tick) begin
                    half_next = half_load;
                    // Stops are only taken at the end of a low phase, never cutting a high one.
                    if (!clk_reg && stop_eff) begin
                        state_next = ST_HALT;
                        stop_next  = 1'b0;
                    end else begin
                        clk_next = ~clk_reg;
                    end
                end else begin
                    half_next = half_reg - HALF_W'(1);
                end
            end
            ST_STEP_LO: begin
                if (tick) begin
                    clk_next   = 1'b1;
                    state_next = ST_STEP_HI;
                    half_next  = LOAD_FAST;
                end else begin
                    half_next = half_reg - HALF_W'(1);
                end
            end
            default: begin
                if (tick) begin
                    clk_next   = 1'b0;
                    state_next = ST_HALT;
                end else begin
                    half_next = half_reg - HALF_W'(1);
                end
            end
        endcase
    end

    assign cnt_next = cnt_reg + {15'd0, clk_next & ~clk_reg};

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state_reg   <= ST_HALT;
            half_reg    <= '0;
            clk_reg     <= 1'b0;
            stop_reg    <= 1'b0;
            running_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            half_reg    <= half_next;
            clk_reg     <= clk_next;
            stop_reg    <= stop_next;
            running_reg <= (state_next == ST_RUN);
            cnt_reg     <= cnt_next;
        end
    end

    assign cpu_clock = clk_reg;
    assign running   = running_reg;
    assign cyc_count = cnt_reg;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Scoreboard bench for cpu_clock_ctrl: a behavioural model predicts every cpu_clock/running
// change; a negedge monitor matches DUT output changes against the queued predictions.
module tb_cpu_clock_ctrl;

    localparam int DEB = 4;
    localparam int HS  = 8;
    localparam int HM  = 4;
    localparam int HF  = 2;
    localparam int HU  = 1;

    logic        clock = 1'b0;
    logic        reset_N = 1'b0;
    logic        btn_run_N = 1'b1;
    logic        btn_step_N = 1'b1;
    logic [1:0]  sw_speed = 2'd1;
    logic        cpu_clock;
    logic        running;
    logic [15:0] cyc_count;

    cpu_clock_ctrl #(
        .DEB_W(20), .DEB_CYCLES(DEB), .HALF_W(25),
        .HALF_SLOW(HS), .HALF_MID(HM), .HALF_FAST(HF), .HALF_FULL(HU)
    ) dut (
        .clock(clock), .reset_N(reset_N), .btn_run_N(btn_run_N), .btn_step_N(btn_step_N),
        .sw_speed(sw_speed), .cpu_clock(cpu_clock), .running(running), .cyc_count(cyc_count)
    );

    always #5 clock = ~clock;

    int edges = 0;
    always @(posedge clock) edges <= edges + 1;

    typedef struct {
        int          cyc;
        logic        clk;
        logic        run;
        logic [15:0] cnt;
    } ev_t;

    ev_t exp_q[$];
    ev_t e;
    int  total = 0;
    int  bad = 0;

    // ---------------- behavioural reference model ----------------
    localparam int M_HALT = 0, M_RUN = 1, M_SLO = 2, M_SHI = 3;
    int          m_mode;
    bit          m_clk, m_stop;
    int          m_left;
    logic [15:0] m_cnt;
    bit          m_dly1[2], m_dly2[2], m_deb[2], m_press[2];
    int          m_streak[2];

    function automatic int half_of(input logic [1:0] spd);
        case (spd)
            2'd0: return HS;
            2'd1: return HM;
            2'd2: return HF;
            default: return HU;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_HALT; m_clk = 0; m_stop = 0; m_left = 0; m_cnt = 16'h0;
        for (int b = 0; b < 2; b++) begin
            m_dly1[b] = 1; m_dly2[b] = 1; m_deb[b] = 1; m_press[b] = 0; m_streak[b] = 0;
        end
    endtask

    // Predict the effect of one board-clock edge given the raw buttons held before it.
    task automatic model_edge(input bit r_raw, input bit s_raw, input logic [1:0] spd, input int idx);
        bit r, s, old_clk, old_run, want_stop;
        bit raw[2];
        r = m_press[0];
        s = m_press[1];
        old_clk = m_clk;
        old_run = (m_mode == M_RUN);
        if (m_mode == M_HALT) begin
            if (r) begin m_mode = M_RUN; m_left = half_of(spd); end
            else if (s) begin m_mode = M_SLO; m_left = HF; end
        end else begin
            want_stop = (m_mode == M_RUN) ? (m_stop ^ r) : 1'b0;
            m_left--;
            if (m_mode == M_RUN) m_stop = want_stop;
            if (m_left == 0) begin
                case (m_mode)
                    M_RUN: begin
                        m_left = half_of(spd);
                        if (!m_clk && want_stop) begin m_mode = M_HALT; m_stop = 0; end
                        else m_clk = !m_clk;
                    end
                    M_SLO: begin m_clk = 1; m_mode = M_SHI; m_left = HF; end
                    default: begin m_clk = 0; m_mode = M_HALT; end
                endcase
            end
        end
        if (m_clk && !old_clk) m_cnt = m_cnt + 16'd1;
        raw[0] = r_raw;
        raw[1] = s_raw;
        for (int b = 0; b < 2; b++) begin
            m_press[b] = 0;
            if (m_dly2[b] != m_deb[b]) begin
                m_streak[b]++;
                if (m_streak[b] == DEB) begin
                    m_deb[b] = m_dly2[b];
                    m_streak[b] = 0;
                    m_press[b] = !m_deb[b];
                end
            end else begin
                m_streak[b] = 0;
            end
            m_dly2[b] = m_dly1[b];
            m_dly1[b] = raw[b];
        end
        if (m_clk != old_clk || (m_mode == M_RUN) != old_run)
            exp_q.push_back('{cyc: idx, clk: m_clk, run: (m_mode == M_RUN), cnt: m_cnt});
    endtask

    // ---------------- monitor ----------------
    logic prev_clk = 1'b0, prev_run = 1'b0;
    always @(negedge clock) begin
        if (!reset_N) begin
            prev_clk = 1'b0;
            prev_run = 1'b0;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < edges) begin
                e = exp_q.pop_front();
                total++; bad++;
                $display("FAIL missed_event: cyc=%0d got clk=%0b run=%0b want clk=%0b run=%0b",
                         e.cyc, cpu_clock, running, e.clk, e.run);
            end
            if (cpu_clock !== prev_clk || running !== prev_run) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: cyc=%0d got clk=%0b run=%0b want no change",
                             edges, cpu_clock, running);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != edges || e.clk !== cpu_clock || e.run !== running || e.cnt !== cyc_count) begin
                        bad++;
                        $display("FAIL event: got cyc=%0d clk=%0b run=%0b cnt=%h want cyc=%0d clk=%0b run=%0b cnt=%h",
                                 edges, cpu_clock, running, cyc_count, e.cyc, e.clk, e.run, e.cnt);
                    end else begin
                        $display("ev cyc=%0d clk=%0b run=%0b cnt=%h", edges, cpu_clock, running, cyc_count);
                    end
                end
                prev_clk = cpu_clock;
                prev_run = running;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    task automatic cyc1(input bit r, input bit s);
        btn_run_N = r;
        btn_step_N = s;
        model_edge(r, s, sw_speed, edges + 1);
        @(negedge clock); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc1(1'b1, 1'b1);
    endtask

    // mask bit0 = run, bit1 = step; buttons held low for len cycles.
    task automatic hold(input int mask, input int len);
        repeat (len) cyc1(!mask[0], !mask[1]);
    endtask

    task automatic press(input int mask);
        hold(mask, 6);
        idle(8);
    endtask

    task automatic wait_clk_high();
        bit seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (cpu_clock === 1'b1) begin seen = 1; break; end
            cyc1(1'b1, 1'b1);
        end
        if (!seen) chk("wait_clk_high_timeout", 32'(cpu_clock), 32'h1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_cpu_clock"}, 32'(cpu_clock), 32'h0);
        chk({tag, "_running"},   32'(running),   32'h0);
        chk({tag, "_cyc_count"}, 32'(cyc_count), 32'h0);
    endtask

    task automatic apply_reset();
        reset_N = 1'b0;
        #1;
        exp_q.delete();
        model_reset();
        check_reset_state("reset_async");
        repeat (3) begin @(negedge clock); #1; end
        reset_N = 1'b1;
        idle(10);
        check_reset_state("reset_after");
    endtask

    // ---------------- test sequence ----------------
    initial begin
        model_reset();
        repeat (3) @(negedge clock);
        #1;
        reset_N = 1'b1;
        idle(4);
        check_reset_state("power_on");

        // Debounce: short glitch, valid press, bounce while running.
        sw_speed = 2'd1;
        hold(1, 3); idle(12);
        chk("short_glitch_running", 32'(running), 32'h0);
        hold(1, 6); idle(4);
        chk("press_running", 32'(running), 32'h1);
        hold(1, 2); idle(2); hold(1, 2); idle(2);
        idle(90);
        chk("run_cyc_count", 32'(cyc_count), 32'(m_cnt));

        // Stop requested during a high phase.
        wait_clk_high();
        press(1);
        idle(20);
        chk("stopped_running", 32'(running), 32'h0);
        chk("stopped_clock", 32'(cpu_clock), 32'h0);

        // Asynchronous reset while the CPU clock is high.
        press(1);
        wait_clk_high();
        apply_reset();

        // Single step, back-to-back step, run press overlapping a step, step while running.
        press(2); idle(6);
        chk("step_count", 32'(cyc_count), 32'h1);
        hold(2, 6); idle(10);
        for (int i = 0; i < 8; i++) cyc1(!(i >= 2), !(i < 6));
        idle(20);
        press(1); press(2); idle(20); press(1); idle(20);

        // Speed change mid-half-period.
        sw_speed = 2'd0;
        hold(1, 6); idle(3);
        sw_speed = 2'd3;
        idle(20);
        press(1); idle(20);

        // Counter wrap from a preloaded value.
        force dut.cnt_reg = 16'hFFF8;
        #1;
        release dut.cnt_reg;
        m_cnt = 16'hFFF8;
        press(1); idle(20); press(1); idle(10);
        chk("wrap_count", 32'(cyc_count), 32'(m_cnt));

        // Run and step together from HALT.
        press(3); idle(4);
        chk("run_wins", 32'(running), 32'h1);
        press(1); idle(30);

        // Randomized operator activity.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) sw_speed = 2'($urandom_range(0, 3));
            hold($urandom_range(0, 3), $urandom_range(1, 8));
            idle($urandom_range(0, 24));
        end
        idle(40);
        chk("final_count", 32'(cyc_count), 32'(m_cnt));
        chk("final_running", 32'(running), 32'(m_mode == M_RUN));
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
